// File: rtl/gc_stream_pkg.sv
// Shared types and tag encodings for the GarbledCircuit stream serializer.
package gc_stream_pkg;

  localparam int unsigned GC_S = 5;
  localparam int unsigned GC_K = 128;

  typedef enum logic [1:0] {
    LABEL = 2'd0,
    KEY   = 2'd1,
    TABLE = 2'd2,
    MASK  = 2'd3
  } rec_type_t;

  // Record as seen at the default GarbledCircuit widths.
  typedef struct packed {
    rec_type_t         rtype;
    logic              last;
    logic [GC_S-1:0]   index;
    logic [GC_K-1:0]   data;
  } gc_rec_t;

  localparam logic [2:0] TAG_KEY   = 3'b001;
  localparam logic [2:0] TAG_TABLE = 3'b010;
  localparam logic [2:0] TAG_MASK  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gc_dual_write_fifo.sv
// Two-write / one-read FIFO. Lane 0 is stored ahead of lane 1 when both write.
module gc_dual_write_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we0,
  input  logic [W-1:0]             wd0,
  input  logic                     we1,
  input  logic [W-1:0]             wd1,
  input  logic                     re,
  output logic [W-1:0]             rd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] wp_lane1;
  logic          pop;

  // Lane 1 takes the slot after lane 0 only if lane 0 also writes.
  assign wp_lane1 = wp + AW'(we0);
  assign pop      = re && (count != '0);
  assign rd       = mem[rp];

  // Storage array, no reset needed: contents are only observed when count != 0.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (we0) mem[wp]       <= wd0;
      if (we1) mem[wp_lane1] <= wd1;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(we0) + AW'(we1);
      rp    <= rp + AW'(pop);
      count <= count + CW'(we0) + CW'(we1) - CW'(pop);
    end
  end

endmodule

// File: rtl/gc_stream_serializer.sv
// Serializes GarbledCircuit dual-lane output into a single back-pressurable record stream.
module gc_stream_serializer
  import gc_stream_pkg::*;
#(
  parameter int unsigned S     = 5,
  parameter int unsigned K     = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    tag,
  input  logic [S-1:0]  index0,
  input  logic [S-1:0]  index1,
  input  logic [K-1:0]  data0,
  input  logic [K-1:0]  data1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_type,
  output logic [S-1:0]  out_index,
  output logic [K-1:0]  out_data,
  output logic          out_last,
  output logic          done,
  output logic          overflow,
  output logic [15:0]   rec_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    rec_type_t     rtype;
    logic          last;
    logic [S-1:0]  index;
    logic [K-1:0]  data;
  } rec_t;

  localparam int unsigned RW = $bits(rec_t);

  state_t          state;
  rec_t            rec0;
  rec_t            rec1;
  rec_t            head;
  rec_t            shown;
  logic [RW-1:0]   head_bits;
  logic            req0;
  logic            req1;
  logic            we0;
  logic            we1;
  logic            is_mask;
  logic            drop;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free;

  // Tag decode into up to two records; only active while streaming and not restarting.
  always_comb begin
    req0        = 1'b0;
    req1        = 1'b0;
    is_mask     = 1'b0;
    rec0        = '0;
    rec1        = '0;
    rec0.data   = data0;
    rec1.data   = data1;
    rec0.index  = index0;
    rec1.index  = index1;
    if (state == ST_STREAM && !start) begin
      if (tag[2]) begin
        req0       = tag[0];
        req1       = tag[1];
        rec0.rtype = LABEL;
        rec1.rtype = LABEL;
      end else begin
        case (tag)
          TAG_KEY: begin
            req0       = 1'b1;
            req1       = 1'b1;
            rec0.rtype = KEY;
            rec1.rtype = KEY;
            rec0.index = '0;
            rec1.index = S'(1);
          end
          TAG_TABLE: begin
            req0       = 1'b1;
            req1       = 1'b1;
            rec0.rtype = TABLE;
            rec1.rtype = TABLE;
          end
          TAG_MASK: begin
            req0       = 1'b1;
            is_mask    = 1'b1;
            rec0.rtype = MASK;
            rec0.index = '0;
            rec0.last  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Capacity check against pre-read occupancy; lane 1 is dropped first.
  always_comb begin
    free = CW'(DEPTH) - count;
    we0  = req0 && (free != '0);
    we1  = req1 && (free >= (req0 ? CW'(2) : CW'(1)));
    drop = (req0 && !we0) || (req1 && !we1);
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !start;
  assign head      = head_bits;
  assign shown     = out_valid ? head : '0;
  assign out_type  = shown.rtype;
  assign out_index = shown.index;
  assign out_data  = shown.data;
  assign out_last  = shown.last;
  assign done      = (state == ST_DONE);

  gc_dual_write_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .we0   (we0),
    .wd0   (rec0),
    .we1   (we1),
    .wd1   (rec1),
    .re    (pop),
    .rd    (head_bits),
    .count (count)
  );

  // Run-control FSM; start restarts from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (start) begin
      state <= ST_STREAM;
    end else begin
      case (state)
        ST_STREAM: if (is_mask) state <= ST_DRAIN;
        ST_DRAIN:  if (count == '0 || (count == CW'(1) && pop)) state <= ST_DONE;
        default:   ;
      endcase
    end
  end

  // Sticky overflow flag and saturating handshake counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      rec_count <= '0;
    end else if (start) begin
      overflow  <= 1'b0;
      rec_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (pop && rec_count != '1) rec_count <= rec_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_gc_stream_serializer.sv
// Directed bench for gc_stream_serializer (S=5, K=128, DEPTH=16).
`timescale 1ns/1ps
module tb_gc_stream_serializer;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    tag = '0;
  logic [4:0]    index0 = '0;
  logic [4:0]    index1 = '0;
  logic [127:0]  data0 = '0;
  logic [127:0]  data1 = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [1:0]    out_type;
  logic [4:0]    out_index;
  logic [127:0]  out_data;
  logic          out_last;
  logic          done;
  logic          overflow;
  logic [15:0]   rec_count;

  int            vectors = 0;
  int            miscompares = 0;
  logic [135:0]  exp_q[$];
  logic [135:0]  got_q[$];
  bit            toggle = 1'b0;
  bit            prev_stall = 1'b0;
  logic [127:0]  prev_data = '0;
  logic [4:0]    prev_index = '0;

  always #5 clk = ~clk;

  gc_stream_serializer #(
    .S     (5),
    .K     (128),
    .DEPTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tag       (tag),
    .index0    (index0),
    .index1    (index1),
    .data0     (data0),
    .data1     (data1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_index (out_index),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done),
    .overflow  (overflow),
    .rec_count (rec_count)
  );

  function automatic logic [127:0] mk(input int grp, input int c, input int lane);
    return {16'hA5C3, 8'(grp), 8'(lane), 32'(c), 64'h0123_4567_89AB_CDEF};
  endfunction

  function automatic logic [135:0] rec(input logic [1:0] t, input logic [4:0] i,
                                       input logic l, input logic [127:0] d);
    return {t, i, l, d};
  endfunction

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: sample at negedge (capture handshakes, check stall hold), return at posedge+1.
  task automatic step();
    @(negedge clk);
    if (out_valid && out_ready) got_q.push_back(rec(out_type, out_index, out_last, out_data));
    if (prev_stall && out_valid)
      check("stall_hold", 256'({out_index, out_data}), 256'({prev_index, prev_data}));
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_index = out_index;
    @(posedge clk);
    #1;
    if (toggle) out_ready = !out_ready;
  endtask

  task automatic drive(input logic [2:0] t, input logic [4:0] i0, input logic [4:0] i1,
                       input logic [127:0] d0, input logic [127:0] d1);
    step();
    start = 1'b0; tag = t; index0 = i0; index1 = i1; data0 = d0; data1 = d1;
  endtask

  task automatic idle();
    drive(3'b000, 5'd0, 5'd0, '0, '0);
  endtask

  task automatic do_start();
    step();
    start = 1'b1; tag = 3'b000;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done !== 1'b1; i++) step();
    check("done", 256'(done), 256'(1'b1));
  endtask

  task automatic compare_run(input string name);
    check({name, "_count"}, 256'(got_q.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_rec%0d", name, i), 256'(got_q[i]), 256'(exp_q[i]));
  endtask

  // 23 labels, 2 keys, 16 table entries, mask; each active cycle followed by ngap idle cycles.
  task automatic run42(input int ngap);
    for (int k = 0; k < 12; k++) begin
      drive((k == 11) ? 3'b101 : 3'b111, 5'(2*k), 5'(2*k+1), mk(1, k, 0), mk(1, k, 1));
      exp_q.push_back(rec(2'd0, 5'(2*k), 1'b0, mk(1, k, 0)));
      if (k < 11) exp_q.push_back(rec(2'd0, 5'(2*k+1), 1'b0, mk(1, k, 1)));
      for (int g = 0; g < ngap; g++) idle();
    end
    drive(3'b001, 5'd7, 5'd9, mk(2, 0, 0), mk(2, 0, 1));
    exp_q.push_back(rec(2'd1, 5'd0, 1'b0, mk(2, 0, 0)));
    exp_q.push_back(rec(2'd1, 5'd1, 1'b0, mk(2, 0, 1)));
    for (int g = 0; g < ngap; g++) idle();
    for (int k = 0; k < 8; k++) begin
      drive(3'b010, 5'(2*k), 5'(2*k+1), mk(3, k, 0), mk(3, k, 1));
      exp_q.push_back(rec(2'd2, 5'(2*k), 1'b0, mk(3, k, 0)));
      exp_q.push_back(rec(2'd2, 5'(2*k+1), 1'b0, mk(3, k, 1)));
      for (int g = 0; g < ngap; g++) idle();
    end
    drive(3'b011, 5'd17, 5'd3, mk(4, 0, 0), mk(4, 0, 1));
    exp_q.push_back(rec(2'd3, 5'd0, 1'b1, mk(4, 0, 0)));
    // presented in DRAIN: must not produce records
    drive(3'b010, 5'd1, 5'd2, mk(5, 0, 0), mk(5, 0, 1));
    idle();
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check("rst_valid", 256'(out_valid), 256'(1'b0));
    check("rst_last", 256'(out_last), 256'(1'b0));
    check("rst_done", 256'(done), 256'(1'b0));
    check("rst_overflow", 256'(overflow), 256'(1'b0));
    check("rst_rec_count", 256'(rec_count), 256'(16'd0));
    check("rst_fields", 256'({out_type, out_index, out_data}), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Asynchronous reset with 5 records queued
    out_ready = 1'b0;
    do_start();
    drive(3'b111, 5'd0, 5'd1, mk(0, 0, 0), mk(0, 0, 1));
    drive(3'b111, 5'd2, 5'd3, mk(0, 1, 0), mk(0, 1, 1));
    drive(3'b101, 5'd4, 5'd5, mk(0, 2, 0), mk(0, 2, 1));
    idle();
    check("mid_valid_before", 256'(out_valid), 256'(1'b1));
    check("mid_head_data", 256'(out_data), 256'(mk(0, 0, 0)));
    #2 rst = 1'b0;
    #1;
    check("async_valid", 256'(out_valid), 256'(1'b0));
    check("async_rec_count", 256'(rec_count), 256'(16'd0));
    check("async_overflow", 256'(overflow), 256'(1'b0));
    check("async_data", 256'(out_data), 256'(0));
    step();
    step();
    rst = 1'b1;
    prev_stall = 1'b0;

    // IDLE ignores tags
    out_ready = 1'b1;
    got_q.delete();
    drive(3'b111, 5'd3, 5'd4, mk(9, 0, 0), mk(9, 0, 1));
    drive(3'b010, 5'd5, 5'd6, mk(9, 1, 0), mk(9, 1, 1));
    idle(); idle(); idle();
    check("idle_valid", 256'(out_valid), 256'(1'b0));
    check("idle_recs", 256'(got_q.size()), 256'(0));

    // Normal run with out_ready held high
    exp_q.delete(); got_q.delete();
    do_start();
    run42(1);
    compare_run("run1");
    check("run1_rec_count", 256'(rec_count), 256'(16'd42));
    check("run1_overflow", 256'(overflow), 256'(1'b0));
    check("run1_valid_end", 256'(out_valid), 256'(1'b0));

    // Back-pressure: 20 cycles of two records with no reads
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    do_start();
    check("bp_done_clr", 256'(done), 256'(1'b0));
    for (int k = 0; k < 20; k++) begin
      drive(3'b010, 5'(2*k), 5'(2*k+1), mk(6, k, 0), mk(6, k, 1));
      if (k < 8) begin
        exp_q.push_back(rec(2'd2, 5'(2*k), 1'b0, mk(6, k, 0)));
        exp_q.push_back(rec(2'd2, 5'(2*k+1), 1'b0, mk(6, k, 1)));
      end
    end
    idle();
    check("bp_overflow", 256'(overflow), 256'(1'b1));
    check("bp_valid", 256'(out_valid), 256'(1'b1));
    check("bp_rec_count", 256'(rec_count), 256'(16'd0));
    check("bp_head", 256'({out_type, out_index, out_data}), 256'({2'd2, 5'd0, mk(6, 0, 0)}));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) idle();
    check("bp_drained", 256'(out_valid), 256'(1'b0));
    check("bp_drain_count", 256'(rec_count), 256'(16'd16));
    drive(3'b011, 5'd0, 5'd0, mk(7, 0, 0), mk(7, 0, 1));
    exp_q.push_back(rec(2'd3, 5'd0, 1'b1, mk(7, 0, 0)));
    idle();
    wait_done();
    compare_run("bp");
    check("bp_final_count", 256'(rec_count), 256'(16'd17));
    check("bp_overflow_sticky", 256'(overflow), 256'(1'b1));

    // Restart from DONE, then full run with out_ready toggling
    exp_q.delete(); got_q.delete();
    do_start();
    check("rs_done", 256'(done), 256'(1'b0));
    check("rs_rec_count", 256'(rec_count), 256'(16'd0));
    check("rs_overflow", 256'(overflow), 256'(1'b0));
    toggle = 1'b1;
    run42(3);
    toggle = 1'b0;
    out_ready = 1'b1;
    compare_run("run2");
    check("run2_rec_count", 256'(rec_count), 256'(16'd42));
    check("run2_overflow", 256'(overflow), 256'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
